ofm_pool: RTL and testbench
===========================

OFM_POOL -- requirements
Module: ofm_pool

Interface
REQ-001 Parameters, one per line: CP, 61, conv output map width/height (square); MCH, 8, output channels; SHIFT, 8, requant right shift; DW, 25, conv result width; OW, 8, pooled output width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  one-cycle pulse beginning a new feature-map pass (driven with the conv start_conv).
REQ-005 in_valid  in  1  conv result strobe (conv O_wren).
REQ-006 in_addr  in  32  conv result linear address (conv O_ram_addr).
REQ-007 in_data  in  DW  conv result, signed two's complement (conv O_ram_din).
REQ-008 out_valid  out  1  pooled byte valid, single-cycle pulse.
REQ-009 out_addr  out  32  pooled linear address ch*P*P + pr*P + pc, where P = (CP-1)/2 = 30.
REQ-010 out_data  out  OW  pooled value, unsigned.
REQ-011 done  out  1  one-cycle pulse at end of pass.
REQ-012 seq_err  out  1  sticky address-sequence error flag.

Function
REQ-013 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE when input (ch=MCH-1,row=CP-1,col=CP-1) is accepted; DONE->IDLE next cycle with done=1 for that one cycle.
REQ-014 start in any state clears counters, line buffer, seq_err and enters RUN.
REQ-015 in_valid outside RUN is ignored; gaps between in_valid pulses are legal and stall nothing.
REQ-016 Internal counters col, row, ch advance per accepted input in raster order: col 0..CP-1, then row, then ch.
REQ-017 Requant per input: y = 0 if in_data<0, else min(in_data>>>SHIFT, 2^OW-1).
REQ-018 Horizontal pair: even col latches y into hreg; odd col forms h = max(hreg, y).
REQ-019 Vertical pair: even row writes h to linebuf[col>>1]; odd row emits max(linebuf[col>>1], h).
REQ-020 Last column (col=CP-1) and last row (row=CP-1) are consumed but never contribute to output.
REQ-021 Latency: out_valid/out_addr/out_data registered, asserted exactly one cycle after the in_valid cycle completing a 2x2 window.
REQ-022 Exactly MCH*P*P = 7200 outputs per pass, in increasing out_addr order.
REQ-023 seq_err set when in_valid in RUN and in_addr != ch*CP*CP + row*CP + col; data still processed by counter position; held until start or reset.
REQ-024 start coincident with in_valid: start wins, input dropped.
REQ-025 Output registers hold last value when out_valid=0.

Reset
REQ-026 On rst=0 at a clock edge: state IDLE, counters 0, hreg 0, linebuf all 0, out_valid 0, out_addr 0, out_data 0, done 0, seq_err 0.
REQ-027 Reset mid-pass abandons the pass with no further out_valid or done until a new start.

Structure
REQ-028 Shared package cnn_pkg holds CP, MCH, SHIFT, DW, OW, P and the FSM state typedef, shared with the conv block and bench.
REQ-029 One sub-module ofm_requant (combinational ReLU, shift, saturate) instantiated once.
REQ-030 Line buffer implemented as P x OW registers, no RAM macro.

Verification
REQ-031 Window at ch0 rows0-1 cols0-1 = 0x100,0x300,0x200,0x050 -> one out_valid, out_addr=0, out_data=3, one cycle after 4th input.
REQ-032 Inputs 25'h1FFFFFF (-1), 0x1234, 0x10000 in one window -> out_data=0xFF (saturated; ReLU yields 0, 0x1234 yields 0x12).
REQ-033 Full pass, random data, random in_valid gaps -> 7200 outputs match golden model, done pulses once after last input, seq_err=0.
REQ-034 Col 60/row 60 inputs = 0xFF00 with all else 0 -> all outputs 0.
REQ-035 in_addr skips one value at ch2 -> seq_err rises next cycle and stays; next start clears it.
REQ-036 rst=0 mid-pass then start -> outputs restart at out_addr=0, no stale linebuf contribution.

Source files
------------

// File: rtl/cnn_pkg.sv
// Constants and FSM state type shared by the conv engine, pooling stage and bench.
// Pure declarations: no latency or backpressure.
package cnn_pkg;
  localparam int CP    = 61;
  localparam int MCH   = 8;
  localparam int SHIFT = 8;
  localparam int DW    = 25;
  localparam int OW    = 8;
  localparam int P     = (CP - 1) / 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/ofm_requant.sv
// ReLU, arithmetic right shift and unsigned saturation of one conv result.
// Latency: combinational; backpressure: none.
module ofm_requant
  import cnn_pkg::*;
#(
  parameter int DW    = cnn_pkg::DW,
  parameter int SHIFT = cnn_pkg::SHIFT,
  parameter int OW    = cnn_pkg::OW
) (
  input  logic signed [DW-1:0] din,
  output logic        [OW-1:0] y
);
  localparam logic [DW-1:0] YMAX = DW'((64'(1) << OW) - 64'(1));

  logic [DW-1:0] shifted;

  always_comb begin
    shifted = din >>> SHIFT;
    if (din[DW-1]) begin
      y = '0;
    end else if (shifted > YMAX) begin
      y = '1;
    end else begin
      y = shifted[OW-1:0];
    end
  end
endmodule

// File: rtl/ofm_pool.sv
// 2x2 stride-2 max pool with requant on the conv output stream, addressed by raster position.
// Latency: 1 cycle from the input completing a window; backpressure: none, every in_valid in RUN is taken.
module ofm_pool
  import cnn_pkg::*;
#(
  parameter int CP    = cnn_pkg::CP,
  parameter int MCH   = cnn_pkg::MCH,
  parameter int SHIFT = cnn_pkg::SHIFT,
  parameter int DW    = cnn_pkg::DW,
  parameter int OW    = cnn_pkg::OW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [31:0]          in_addr,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  output logic [31:0]          out_addr,
  output logic [OW-1:0]        out_data,
  output logic                 done,
  output logic                 seq_err
);
  localparam int PW = (CP - 1) / 2;
  localparam int CW = $clog2(CP);
  localparam int HW = (MCH > 1) ? $clog2(MCH) : 1;

  state_t          state;
  logic [CW-1:0]   col;
  logic [CW-1:0]   row;
  logic [HW-1:0]   ch;
  logic [OW-1:0]   hreg;
  logic [OW-1:0]   linebuf [PW];

  logic [OW-1:0]   y;
  logic [OW-1:0]   h;
  logic [OW-1:0]   lb_rd;
  logic [OW-1:0]   vmax;
  logic [CW-2:0]   lb_idx;
  logic            last_in;
  logic            in_win;
  logic [31:0]     exp_addr;
  logic [31:0]     win_addr;

  ofm_requant #(
    .DW   (DW),
    .SHIFT(SHIFT),
    .OW   (OW)
  ) u_requant (
    .din(in_data),
    .y  (y)
  );

  assign lb_idx   = col[CW-1:1];
  assign last_in  = (ch == HW'(MCH - 1)) && (row == CW'(CP - 1)) && (col == CW'(CP - 1));
  // Odd CP leaves a trailing row/column that never completes a window.
  assign in_win   = (32'(col) < 32'(2 * PW)) && (32'(row) < 32'(2 * PW));
  assign exp_addr = 32'(ch) * 32'(CP * CP) + 32'(row) * 32'(CP) + 32'(col);
  assign win_addr = 32'(ch) * 32'(PW * PW) + 32'(row >> 1) * 32'(PW) + 32'(lb_idx);
  assign h        = (y > hreg) ? y : hreg;
  assign lb_rd    = in_win ? linebuf[lb_idx] : '0;
  assign vmax     = (lb_rd > h) ? lb_rd : h;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      ch        <= '0;
      hreg      <= '0;
      for (int i = 0; i < PW; i++) linebuf[i] <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      done      <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (start) begin
        state   <= RUN;
        col     <= '0;
        row     <= '0;
        ch      <= '0;
        hreg    <= '0;
        for (int i = 0; i < PW; i++) linebuf[i] <= '0;
        seq_err <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (in_valid) begin
              if (in_addr != exp_addr) seq_err <= 1'b1;
              if (!col[0]) begin
                hreg <= y;
              end else if (in_win) begin
                if (!row[0]) begin
                  linebuf[lb_idx] <= h;
                end else begin
                  out_valid <= 1'b1;
                  out_addr  <= win_addr;
                  out_data  <= vmax;
                end
              end
              if (col == CW'(CP - 1)) begin
                col <= '0;
                if (row == CW'(CP - 1)) begin
                  row <= '0;
                  ch  <= ch + HW'(1);
                end else begin
                  row <= row + CW'(1);
                end
              end else begin
                col <= col + CW'(1);
              end
              if (last_in) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ofm_pool.sv
// Randomized bench for ofm_pool: a raster-position image model predicts every output cycle.
module tb_ofm_pool;
  import cnn_pkg::*;

  logic          clk;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [31:0]   in_addr;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [31:0]   out_addr;
  logic [OW-1:0] out_data;
  logic          done;
  logic          seq_err;

  ofm_pool dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_addr (out_addr),
    .out_data (out_data),
    .done     (done),
    .seq_err  (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: requantized image of the current pass plus expected outputs for the next cycle.
  int img [MCH][CP][CP];
  bit running = 0;
  int k_pos = 0;
  int e_vld = 0, e_done = 0, e_seq = 0;
  longint e_addr = 0, e_data = 0;

  int n_out = 0, n_done = 0, max_seen = 0;
  bit want_first = 0;
  longint first_addr = -1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int rq(input logic [DW-1:0] d);
    logic signed [DW-1:0] sd;
    int v;
    sd = d;
    if (sd < 0) return 0;
    v = int'(sd) / (1 << SHIFT);
    return (v > (1 << OW) - 1) ? (1 << OW) - 1 : v;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    case ($urandom_range(0, 3))
      0:       return {1'b1, (DW-1)'($urandom)};
      1:       return DW'($urandom_range(0, 65535));
      2:       return DW'($urandom_range(0, 2047));
      default: return {1'b0, (DW-1)'($urandom)};
    endcase
  endfunction

  // One cycle: check outputs produced by the previous cycle's inputs, then drive and model new ones.
  task automatic step(input logic r, input logic st, input logic v,
                      input logic [31:0] a, input logic [DW-1:0] d);
    int c, rr, cc, m;
    @(negedge clk);
    chk("out_valid", longint'(out_valid), longint'(e_vld));
    chk("done", longint'(done), longint'(e_done));
    chk("seq_err", longint'(seq_err), longint'(e_seq));
    chk("out_addr", longint'(out_addr), e_addr);
    chk("out_data", longint'(out_data), e_data);
    if (out_valid) begin
      n_out++;
      if (int'(out_data) > max_seen) max_seen = int'(out_data);
      if (want_first) begin
        first_addr = longint'(out_addr);
        want_first = 0;
      end
    end
    if (done) n_done++;

    rst = r; start = st; in_valid = v; in_addr = a; in_data = d;
    e_vld = 0;
    e_done = 0;
    if (!r) begin
      running = 0; k_pos = 0; e_seq = 0; e_addr = 0; e_data = 0;
    end else if (st) begin
      running = 1; k_pos = 0; e_seq = 0;
    end else if (running && v) begin
      c  = k_pos / (CP * CP);
      rr = (k_pos / CP) % CP;
      cc = k_pos % CP;
      if (a != 32'(k_pos)) e_seq = 1;
      img[c][rr][cc] = rq(d);
      if (rr % 2 == 1 && cc % 2 == 1 && rr < 2 * P && cc < 2 * P) begin
        m = img[c][rr-1][cc-1];
        if (img[c][rr-1][cc] > m) m = img[c][rr-1][cc];
        if (img[c][rr][cc-1] > m) m = img[c][rr][cc-1];
        if (img[c][rr][cc] > m)   m = img[c][rr][cc];
        e_vld  = 1;
        e_addr = longint'(c * P * P + (rr / 2) * P + cc / 2);
        e_data = longint'(m);
      end
      k_pos++;
      if (k_pos == MCH * CP * CP) begin
        running = 0;
        e_done = 1;
      end
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 32'h0, '0);
  endtask

  task automatic send_k(input int k, input logic [DW-1:0] d);
    step(1'b1, 1'b0, 1'b1, 32'(k), d);
  endtask

  task automatic do_start();
    step(1'b1, 1'b1, 1'b0, 32'h0, '0);
  endtask

  int snap;
  int skip_k;
  logic [DW-1:0] d;

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 32'h0, '0);
    idle();
    chk("rst_out_addr", longint'(out_addr), 0);
    chk("rst_out_valid", longint'(out_valid), 0);

    // Single window 0x100,0x300 / 0x200,0x050 -> 3 at address 0.
    do_start();
    for (int k = 0; k <= CP + 1; k++) begin
      d = (k == 0) ? DW'(25'h100) : (k == 1) ? DW'(25'h300) :
          (k == CP) ? DW'(25'h200) : (k == CP + 1) ? DW'(25'h050) : '0;
      send_k(k, d);
      if (k == CP + 1) chk("win1_early", longint'(out_valid), 0);
    end
    idle();
    chk("win1_vld", longint'(out_valid), 1);
    chk("win1_addr", longint'(out_addr), 0);
    chk("win1_data", longint'(out_data), 3);
    idle();
    chk("win1_pulse", longint'(out_valid), 0);
    chk("win1_hold", longint'(out_data), 3);

    // Start with coincident in_valid drops that input; saturation/ReLU window.
    step(1'b1, 1'b1, 1'b1, 32'h0, DW'(25'h0FFFFFF));
    for (int k = 0; k <= CP + 1; k++) begin
      d = (k == 0) ? DW'(25'h1FFFFFF) : (k == 1) ? DW'(25'h1234) :
          (k == CP) ? DW'(25'h10000) : '0;
      send_k(k, d);
    end
    idle();
    chk("sat_vld", longint'(out_valid), 1);
    chk("sat_addr", longint'(out_addr), 0);
    chk("sat_data", longint'(out_data), 8'hFF);

    // Only the discarded last row/column carry data: every output must be 0.
    do_start();
    n_out = 0; max_seen = 0;
    for (int k = 0; k < CP * CP; k++)
      send_k(k, ((k / CP == CP - 1) || (k % CP == CP - 1)) ? DW'(25'hFF00) : '0);
    idle();
    chk("edge_count", longint'(n_out), P * P);
    chk("edge_max", longint'(max_seen), 0);

    // Address skip inside channel 2 raises a sticky seq_err; start clears it.
    do_start();
    skip_k = 2 * CP * CP + 5;
    for (int k = 0; k < skip_k + 12; k++) begin
      send_k((k < skip_k) ? k : k + 1, rnd_data());
      if (k == skip_k) chk("seq_before", longint'(seq_err), 0);
      if (k == skip_k + 1) chk("seq_rise", longint'(seq_err), 1);
    end
    idle();
    chk("seq_sticky", longint'(seq_err), 1);
    do_start();
    idle();
    chk("seq_clear", longint'(seq_err), 0);

    // Reset mid-pass, ignored inputs, then a fresh pass restarting at address 0.
    for (int k = 0; k < 3 * CP; k++) send_k(k, rnd_data());
    step(1'b0, 1'b0, 1'b1, 32'h0, rnd_data());
    step(1'b0, 1'b0, 1'b1, 32'h1, rnd_data());
    snap = n_out;
    for (int k = 0; k < 4; k++) send_k(k, DW'(25'hFFFFF));
    idle();
    idle();
    chk("rst_no_out", longint'(n_out), longint'(snap));
    want_first = 1;
    do_start();
    for (int k = 0; k < 2 * CP; k++) send_k(k, rnd_data());
    idle();
    chk("restart_addr", first_addr, 0);

    // Full pass with random data and random gaps.
    do_start();
    n_out = 0; n_done = 0;
    for (int k = 0; k < MCH * CP * CP; k++) begin
      if ($urandom_range(0, 3) == 0) idle();
      send_k(k, rnd_data());
    end
    send_k(0, rnd_data());
    for (int i = 0; i < 4; i++) idle();
    chk("full_count", longint'(n_out), MCH * P * P);
    chk("full_done", longint'(n_done), 1);
    chk("full_seq", longint'(seq_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
